// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, FSM state encodings and decode helper for the ALU with HI/LO mul/div.
package alu_muldiv_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LUI   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Codes 10xx select the iterative engine; bit1 = divide, bit0 = unsigned.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative radix-2 multiply/divide engine: operand magnitudes are processed unsigned,
// and the sign correction is applied combinationally while in FIX.
module alu_muldiv_core
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_fix,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;       // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_m;       // multiplicand or divisor magnitude
  logic               r_is_mul;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;

  assign w_sign_a = ~i_op[0] & i_a[WIDTH-1];
  assign w_sign_b = ~i_op[0] & i_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -i_a : i_a;
  assign w_mag_b  = w_sign_b ? -i_b : i_b;

  assign w_sum      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_sum, r_p[WIDTH-1:1]};

  // Restoring step: a set top bit of the difference means the trial subtraction underflowed.
  assign w_shift    = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_m};
  assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  assign o_busy = (r_state != ST_IDLE);
  assign o_fix  = (r_state == ST_FIX);

  // Sign fix-up of the finished magnitudes; remainder follows the dividend sign.
  always_comb begin
    w_prod = r_p;
    o_hi   = r_p[2*WIDTH-1:WIDTH];
    o_lo   = r_p[WIDTH-1:0];
    if (r_is_mul) begin
      w_prod = r_neg_q ? -r_p : r_p;
      o_hi   = w_prod[2*WIDTH-1:WIDTH];
      o_lo   = w_prod[WIDTH-1:0];
    end else begin
      o_lo = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
      o_hi = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
    end
  end

  // Engine FSM, iteration counter and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && is_muldiv(i_op)) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_is_mul <= ~i_op[1];
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            if (!i_op[1]) begin
              r_state <= ST_MUL;
              r_p     <= {{WIDTH{1'b0}}, w_mag_b};
              r_m     <= w_mag_a;
            end else if (i_b == '0) begin
              // Divide by zero bypasses the iterations: HI gets A, LO all ones.
              r_state <= ST_FIX;
              r_p     <= {i_a, {WIDTH{1'b1}}};
              r_m     <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_state <= ST_DIV;
              r_p     <= {{WIDTH{1'b0}}, w_mag_a};
              r_m     <= w_mag_b;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          r_p   <= w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ST_FIX;
          else                    r_state <= ST_MUL;
        end
        ST_DIV: begin
          r_p   <= w_div_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ST_FIX;
          else                    r_state <= ST_DIV;
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle ops with a registered result, plus HI/LO multiply/divide
// through the iterative core. Owns Result/Zero/done and the architectural HI/LO registers.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_busy;
  logic             w_fix;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;
  logic             w_accept_alu;
  logic [WIDTH-1:0] w_alu;

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start),
    .i_op    (ALUControl),
    .i_a     (A),
    .i_b     (B),
    .o_busy  (w_busy),
    .o_fix   (w_fix),
    .o_hi    (w_core_hi),
    .o_lo    (w_core_lo)
  );

  assign w_accept_alu = start & ~w_busy & ~is_muldiv(ALUControl);

  // Single-cycle op mux; MFHI/MFLO read the committed HI/LO registers.
  always_comb begin
    w_alu = '0;
    case (ALUControl)
      OP_AND:  w_alu = A & B;
      OP_OR:   w_alu = A | B;
      OP_ADD:  w_alu = A + B;
      OP_LUI:  w_alu = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SUB:  w_alu = A - B;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR:  w_alu = ~(A | B);
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // Result/Zero/done and HI/LO commit; the engine can only be in FIX while busy, so the two sources never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_accept_alu | w_fix;
      if (w_fix) begin
        r_hi     <= w_core_hi;
        r_lo     <= w_core_lo;
        r_result <= w_core_lo;
        r_zero   <= (w_core_lo == '0);
      end else if (w_accept_alu) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end else begin
        r_result <= r_result;
        r_zero   <= r_zero;
      end
    end
  end

  assign busy   = w_busy;
  assign done   = r_done;
  assign Result = r_result;
  assign Zero   = r_zero;
  assign hi     = r_hi;
  assign lo     = r_lo;

endmodule
